// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake bundle between the multi-cycle control FSM (master)
// and the instruction/data memory ports (slave).
interface multicycle_ctrl_fsm_if;
    logic imem_req;
    logic imem_ready;
    logic ir_write;
    logic dmem_req;
    logic dmem_ready;
    logic mem_read;
    logic mem_write;

    modport master (
        output imem_req, ir_write, dmem_req, mem_read, mem_write,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, ir_write, dmem_req, mem_read, mem_write,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 main control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over
// ready-handshaked memories, with ALU latency, memory-wait timeout trap and sticky halt.
//
// state  | meaning
// FETCH  | instruction request outstanding, IR loads on imem_ready
// DECODE | opcode classified, illegal -> FAULT, HALT -> HALT
// EXEC   | ALU busy for 1+ALU_LATENCY cycles, branches resolve on the last one
// MEM    | data request outstanding for LOAD/STORE
// WB     | register write and PC update
// HALT   | absorbing, halted=1
// FAULT  | absorbing, mem_fault=1
module multicycle_ctrl_fsm #(
    parameter int ALU_LATENCY = 0,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_fsm_if.master mem,
    input  logic [6:0]            opcode,
    input  logic                  branch_taken,
    output logic                  alu_src,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic [1:0]            alu_op,
    output logic [1:0]            wr_mux,
    output logic                  pc_write,
    output logic [1:0]            pc_sel,
    output logic                  halted,
    output logic                  mem_fault,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_U, C_LOAD, C_STORE, C_B, C_JAL, C_JALR
    } cls_t;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [1:0] wr_mux;
        logic [1:0] wb_pc_sel;
        logic       halted;
        logic       mem_fault;
    } outs_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_U     = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_HALT  = 7'b1111111;

    localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [2:0]      ALU_LOAD   = 3'(ALU_LATENCY);

    state_t              state;
    cls_t                cls;
    outs_t               outs_q;
    logic [2:0]          alu_cnt;
    logic [WAIT_W-1:0]   wait_cnt;

    cls_t                dec_cls;
    logic                dec_legal;
    logic                dec_halt;
    logic                exec_last;
    logic                b_resolve;
    logic                store_done;

    // Registered outputs are computed for the state being entered, so they
    // line up with the state register on the following cycle.
    function automatic outs_t outs_for(input state_t s, input cls_t c);
        outs_t o;
        o = '0;
        case (s)
            S_FETCH: o.imem_req = 1'b1;
            S_MEM: begin
                o.dmem_req  = 1'b1;
                o.mem_read  = (c == C_LOAD);
                o.mem_write = (c == C_STORE);
            end
            S_WB:    o.reg_write = 1'b1;
            S_HALT:  o.halted    = 1'b1;
            S_FAULT: o.mem_fault = 1'b1;
            default: ;
        endcase
        if (s == S_EXEC || s == S_MEM || s == S_WB) begin
            case (c)
                C_R:     o.alu_op = 2'b10;
                C_I:     begin o.alu_src = 1'b1; o.alu_op = 2'b10; end
                C_U:     begin o.alu_src = 1'b1; o.alu_op = 2'b11; o.wr_mux = 2'b10; end
                C_LOAD:  begin o.alu_src = 1'b1; o.mem_to_reg = 1'b1; end
                C_STORE: o.alu_src = 1'b1;
                C_B:     o.alu_op = 2'b01;
                C_JAL:   begin o.alu_op = 2'b11; o.wr_mux = 2'b01; o.wb_pc_sel = 2'b01; end
                C_JALR:  begin o.alu_src = 1'b1; o.wr_mux = 2'b01; o.wb_pc_sel = 2'b10; end
                default: ;
            endcase
        end
        if (s != S_WB) o.wb_pc_sel = 2'b00;
        return o;
    endfunction

    always_comb begin
        dec_cls   = C_R;
        dec_legal = 1'b1;
        dec_halt  = 1'b0;
        case (opcode)
            OP_R:     dec_cls = C_R;
            OP_I:     dec_cls = C_I;
            OP_U:     dec_cls = C_U;
            OP_LOAD:  dec_cls = C_LOAD;
            OP_STORE: dec_cls = C_STORE;
            OP_B:     dec_cls = C_B;
            OP_JAL:   dec_cls = C_JAL;
            OP_JALR:  dec_cls = C_JALR;
            OP_HALT:  dec_halt = 1'b1;
            default:  dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            cls      <= C_R;
            alu_cnt  <= ALU_LOAD;
            wait_cnt <= WAIT_LOAD;
            outs_q   <= outs_for(S_FETCH, C_R);
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem.imem_ready) begin
                        state  <= S_DECODE;
                        outs_q <= outs_for(S_DECODE, cls);
                    end else if (TIMEOUT_EN && wait_cnt == '0) begin
                        state  <= S_FAULT;
                        outs_q <= outs_for(S_FAULT, cls);
                    end else if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_halt) begin
                        state  <= S_HALT;
                        outs_q <= outs_for(S_HALT, cls);
                    end else if (!dec_legal) begin
                        state  <= S_FAULT;
                        outs_q <= outs_for(S_FAULT, cls);
                    end else begin
                        cls     <= dec_cls;
                        alu_cnt <= ALU_LOAD;
                        state   <= S_EXEC;
                        outs_q  <= outs_for(S_EXEC, dec_cls);
                    end
                end
                S_EXEC: begin
                    if (alu_cnt != 3'd0) begin
                        alu_cnt <= alu_cnt - 3'd1;
                    end else if (cls == C_LOAD || cls == C_STORE) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_MEM;
                        outs_q   <= outs_for(S_MEM, cls);
                    end else if (cls == C_B) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_FETCH;
                        outs_q   <= outs_for(S_FETCH, cls);
                    end else begin
                        state  <= S_WB;
                        outs_q <= outs_for(S_WB, cls);
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ready) begin
                        if (cls == C_LOAD) begin
                            state  <= S_WB;
                            outs_q <= outs_for(S_WB, cls);
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= S_FETCH;
                            outs_q   <= outs_for(S_FETCH, cls);
                        end
                    end else if (TIMEOUT_EN && wait_cnt == '0) begin
                        state  <= S_FAULT;
                        outs_q <= outs_for(S_FAULT, cls);
                    end else if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_WB: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= S_FETCH;
                    outs_q   <= outs_for(S_FETCH, cls);
                end
                S_HALT, S_FAULT: ;
                default: begin
                    state  <= S_FAULT;
                    outs_q <= outs_for(S_FAULT, cls);
                end
            endcase
        end
    end

    // Handshake-qualified strobes depend on this cycle's ready/compare inputs.
    assign exec_last  = (state == S_EXEC) && (alu_cnt == 3'd0);
    assign b_resolve  = exec_last && (cls == C_B);
    assign store_done = (state == S_MEM) && (cls == C_STORE) && mem.dmem_ready;

    assign mem.imem_req  = outs_q.imem_req  & ~reset;
    assign mem.ir_write  = ~reset & (state == S_FETCH) & mem.imem_ready;
    assign mem.dmem_req  = outs_q.dmem_req  & ~reset;
    assign mem.mem_read  = outs_q.mem_read  & ~reset;
    assign mem.mem_write = outs_q.mem_write & ~reset;

    assign alu_src    = outs_q.alu_src    & ~reset;
    assign mem_to_reg = outs_q.mem_to_reg & ~reset;
    assign reg_write  = outs_q.reg_write  & ~reset;
    assign alu_op     = reset ? 2'b00 : outs_q.alu_op;
    assign wr_mux     = reset ? 2'b00 : outs_q.wr_mux;
    assign pc_write   = ~reset & (outs_q.reg_write | b_resolve | store_done);
    assign pc_sel     = reset ? 2'b00 : (b_resolve ? {1'b0, branch_taken} : outs_q.wb_pc_sel);
    assign halted     = outs_q.halted    & ~reset;
    assign mem_fault  = outs_q.mem_fault & ~reset;
    assign state_dbg  = reset ? 3'd0 : state;

endmodule
